gmm_dist_quant: RTL

GMM_DIST_QUANT -- requirements
Module: gmm_dist_quant

---
 rtl/gmm_dist_quant.sv | 99 +++++++++
 1 files changed

// File: rtl/gmm_dist_quant.sv
`default_nettype none
// ============================================================================
//  Module      : gmm_dist_quant
//  Description : Quantises the distance |pixel - mean| in units of sigma to
//                an index 0..SAT using repeated subtraction. The index drives
//                the exp lookup table of a Gaussian mixture model stage.
//  Revision    : 1.0  initial release
// ============================================================================
module gmm_dist_quant #(
    parameter int W   = 8,
    parameter int SAT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] pixel,
    input  logic [W-1:0] mean,
    input  logic [W-1:0] sigma,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   grey
);

    localparam logic [7:0] c_SAT = 8'(SAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_sig;
    logic [7:0]     r_cnt;
    logic [W-1:0]   w_diff;

    // Unsigned absolute difference of the operands presented this cycle
    always_comb begin
        w_diff = (pixel >= mean) ? (pixel - mean) : (mean - pixel);
    end

    // Control FSM with registered handshake outputs and quotient datapath.
    // A zero sigma still passes through one CALC cycle so its result appears
    // one edge after accept, the same as any q=0 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            grey      <= 8'd0;
            r_cnt     <= 8'd0;
            r_rem     <= '0;
            r_sig     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem    <= w_diff;
                        r_sig    <= sigma;
                        r_cnt    <= 8'd0;
                        in_ready <= 1'b0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_sig == '0) begin
                        grey      <= (r_rem == '0) ? 8'd0 : c_SAT;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if ((r_rem < r_sig) || (r_cnt == c_SAT)) begin
                        grey      <= r_cnt;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        // Subtract only when rem >= sig, so rem never wraps
                        r_rem <= r_rem - r_sig;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
